// File: rtl/hash_breaker_pkg.sv
// rtl/hash_breaker_pkg.sv - shared constants for the hash-breaker block formatting path
package hash_breaker_pkg;

    localparam int         BLOCK_BITS  = 512;
    localparam int         BLOCK_BYTES = BLOCK_BITS / 8;
    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         LEN_OFFSET  = 56;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - one valid/ready pipeline register slice, parameterised by data width
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         load;

    // The slice can take new data when empty or when its content leaves this cycle.
    assign in_ready_o = !reset && (!valid_q || out_ready_i);
    assign load       = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/candidate_packer.sv
// rtl/candidate_packer.sv - pads one candidate into a 512-bit hash block; BIG_ENDIAN_LEN_EN selects big-endian length
module candidate_packer
    import hash_breaker_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int ID_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*MAX_LEN-1:0]  chars,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BLOCK_BITS-1:0] block,
    output logic [ID_W-1:0]       cand_id,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int S1_W      = 8*MAX_LEN + 6 + ID_W;
    localparam int S2_W      = BLOCK_BITS + ID_W;
    localparam int CHAR_BITS = LEN_OFFSET * 8;

    logic [ID_W-1:0]      id_q, id_d;
    logic [5:0]           len_c;
    logic                 accept;

    logic [S1_W-1:0]      s1_data;
    logic                 s1_valid;
    logic                 s2_in_ready;
    logic [8*MAX_LEN-1:0] s1_chars;
    logic [5:0]           s1_len;
    logic [ID_W-1:0]      s1_id;

    logic [CHAR_BITS-1:0] chars_ext;
    logic [63:0]          bit_len;
    logic [BLOCK_BITS-1:0] block_c;
    logic [S2_W-1:0]      s2_data;

    // Scanning downward leaves the lowest zero position, i.e. the first terminator.
    always_comb begin
        len_c = 6'(MAX_LEN);
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (chars[8*i +: 8] == 8'h00) begin
                len_c = 6'(i);
            end
        end
    end

    assign accept = in_valid && in_ready;
    assign id_d   = id_q + ID_W'(accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            id_q <= '0;
        end else begin
            id_q <= id_d;
        end
    end

    pipe_reg #(.W(S1_W)) u_stage1 (
        .clk         (clk),
        .reset       (reset),
        .in_data_i   ({id_q, len_c, chars}),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (s1_data),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready)
    );

    assign s1_chars = s1_data[8*MAX_LEN-1:0];
    assign s1_len   = s1_data[8*MAX_LEN +: 6];
    assign s1_id    = s1_data[S1_W-1 -: ID_W];

    assign chars_ext = CHAR_BITS'(s1_chars);
    assign bit_len   = {55'd0, s1_len, 3'b000};

    // Bytes past the terminator are dropped here, so trailing junk never reaches the block.
    always_comb begin
        block_c = '0;
        for (int j = 0; j < LEN_OFFSET; j++) begin
            if (6'(j) < s1_len) begin
                block_c[8*j +: 8] = chars_ext[8*j +: 8];
            end else if (6'(j) == s1_len) begin
                block_c[8*j +: 8] = PAD_BYTE;
            end
        end
        for (int k = 0; k < 8; k++) begin
`ifdef BIG_ENDIAN_LEN_EN
            block_c[8*(BLOCK_BYTES-1-k) +: 8] = bit_len[8*k +: 8];
`else
            block_c[8*(LEN_OFFSET+k) +: 8] = bit_len[8*k +: 8];
`endif
        end
    end

    pipe_reg #(.W(S2_W)) u_stage2 (
        .clk         (clk),
        .reset       (reset),
        .in_data_i   ({s1_id, block_c}),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .out_data_o  (s2_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    assign block   = s2_data[BLOCK_BITS-1:0];
    assign cand_id = s2_data[S2_W-1 -: ID_W];

endmodule
